multicycle_main_fsm: RTL and testbench

//  Main control FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).

---
 rtl/multicycle_main_fsm.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU,
// beq, jal). It steps the shared ALU, memory port, IR and register file one
// state per cycle, drives ALUOp into the ALU decoder and counts retired
// instructions.
//
// Optional build macro MEM_READY_EN: FETCH, MEMREAD and MEMWRITE wait for
// mem_ready. A wait that lasts MEM_TIMEOUT cycles is abandoned with a mem_err
// pulse and a return to FETCH. Without the macro every state lasts one cycle,
// mem_ready is ignored and mem_err is held at 0.
module multicycle_main_fsm #(
  parameter int INSTRET_W   = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic                 illegal_op,
  output logic                 mem_err,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [3:0] state;
  logic [3:0] state_next;
  logic [3:0] out_state;
  logic       retire;
  logic       op_legal;
  logic       mem_ok;
  logic       timeout;
  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;

`ifdef MEM_READY_EN
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             wait_state;

  assign mem_ok     = mem_ready;
  assign wait_state = (state == S_FETCH) || (state == S_MEMREAD) ||
                      (state == S_MEMWRITE);
  assign timeout    = wait_state && !mem_ready &&
                      (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Count consecutive not-ready cycles of the current memory wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (wait_state && !mem_ready && !timeout) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  logic        unused_mem_ready;
  logic [31:0] unused_timeout_cfg;

  assign mem_ok             = 1'b1;
  assign timeout            = 1'b0;
  assign unused_mem_ready   = mem_ready;
  assign unused_timeout_cfg = 32'(MEM_TIMEOUT);
`endif

  // Opcodes this core implements; anything else is flagged in DECODE.
  always_comb begin
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_legal = 1'b1;
      default:                                  op_legal = 1'b0;
    endcase
  end

  // Next-state selection and detection of a retiring instruction.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ok)       state_next = S_DECODE;
        else if (timeout) state_next = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ok)       state_next = S_MEMWB;
        else if (timeout) state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        if (mem_ok) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end else if (timeout) begin
          state_next = S_FETCH;
        end
      end
      S_EXECUTER, S_EXECUTEI, S_JAL: state_next = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (reset) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

  // While reset is held the selects must already show their FETCH values,
  // even before the first reset edge has loaded the state register.
  assign out_state = reset ? S_FETCH : state;

  // Moore decode of datapath selects and raw (ungated) strobes.
  always_comb begin
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    case (out_state)
      S_FETCH: begin
        ir_write_raw = mem_ok;
        pc_update    = mem_ok;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = mem_ok;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are suppressed during reset so an abandoned instruction never
  // completes a partial write.
  assign PCWrite    = !reset && (pc_update || (branch && zero));
  assign IRWrite    = !reset && ir_write_raw;
  assign MemWrite   = !reset && mem_write_raw;
  assign RegWrite   = !reset && reg_write_raw;
  assign illegal_op = !reset && (state == S_DECODE) && !op_legal;
  assign mem_err    = !reset && timeout;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm. The stimulus process pushes the
// expected outputs of each cycle into a queue; a monitor pops one entry per
// cycle on the falling edge and compares. Built with MEM_READY_EN it also
// exercises memory waits and the timeout path (MEM_TIMEOUT = 4).
module tb_multicycle_main_fsm;

  // Field order: PCWrite AdrSrc MemWrite IRWrite RegWrite illegal_op mem_err
  //              ResultSrc ALUSrcA ALUSrcB ALUOp
  typedef logic [14:0] exp_t;

  typedef struct {
    int          id;
    exp_t        outs;
    logic [31:0] instret;
  } entry_t;

  localparam exp_t E_RST  = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam exp_t E_FW   = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam exp_t E_F    = {5'b10010, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam exp_t E_D    = {5'b00000, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
  localparam exp_t E_DI   = {5'b00000, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
  localparam exp_t E_MA   = {5'b00000, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
  localparam exp_t E_MR   = {5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam exp_t E_MRE  = {5'b01000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam exp_t E_MWB  = {5'b00001, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam exp_t E_MW   = {5'b01100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam exp_t E_ER   = {5'b00000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10};
  localparam exp_t E_EI   = {5'b00000, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
  localparam exp_t E_AWB  = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam exp_t E_BT   = {5'b10000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
  localparam exp_t E_BN   = {5'b00000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
  localparam exp_t E_J    = {5'b10000, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1110011;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic        illegal_op, mem_err;
  logic [31:0] instret;

  entry_t      sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_id = 0;

  multicycle_main_fsm #(.INSTRET_W(32), .MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .illegal_op (illegal_op),
    .mem_err    (mem_err),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One clock cycle of stimulus: drive inputs, queue the expected response.
  task automatic cyc(input logic rst, input logic [6:0] o, input logic z,
                     input logic mr, input exp_t e, input logic [31:0] ir);
    entry_t ent;
    reset     = rst;
    op        = o;
    zero      = z;
    mem_ready = mr;
    ent.id      = cyc_id;
    ent.outs    = e;
    ent.instret = ir;
    sb_q.push_back(ent);
    cyc_id++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare one queued expectation per cycle, mid-cycle.
  initial begin
    entry_t ent;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        ent = sb_q.pop_front();
        check($sformatf("cycle %0d outputs", ent.id),
              32'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op,
                   mem_err, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}),
              32'(ent.outs));
        check($sformatf("cycle %0d instret", ent.id), instret, ent.instret);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    op        = 7'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Reset held: strobes low, FETCH selects, counter cleared.
    cyc(1, OP_LW, 0, 1, E_RST, 0);
    cyc(1, OP_LW, 0, 1, E_RST, 0);
    // lw: five cycles, RegWrite only in MEMWB.
    cyc(0, OP_LW, 0, 1, E_F,   0);
    cyc(0, OP_LW, 0, 1, E_D,   0);
    cyc(0, OP_LW, 0, 1, E_MA,  0);
    cyc(0, OP_LW, 0, 1, E_MR,  0);
    cyc(0, OP_LW, 0, 1, E_MWB, 0);
    // R-type.
    cyc(0, OP_R, 0, 1, E_F,   1);
    cyc(0, OP_R, 0, 1, E_D,   1);
    cyc(0, OP_R, 0, 1, E_ER,  1);
    cyc(0, OP_R, 0, 1, E_AWB, 1);
    // sw.
    cyc(0, OP_SW, 0, 1, E_F,  2);
    cyc(0, OP_SW, 0, 1, E_D,  2);
    cyc(0, OP_SW, 0, 1, E_MA, 2);
    cyc(0, OP_SW, 0, 1, E_MW, 2);
    // I-type ALU.
    cyc(0, OP_I, 0, 1, E_F,   3);
    cyc(0, OP_I, 0, 1, E_D,   3);
    cyc(0, OP_I, 0, 1, E_EI,  3);
    cyc(0, OP_I, 0, 1, E_AWB, 3);
    // beq taken (zero high throughout) and not taken.
    cyc(0, OP_BEQ, 1, 1, E_F,  4);
    cyc(0, OP_BEQ, 1, 1, E_D,  4);
    cyc(0, OP_BEQ, 1, 1, E_BT, 4);
    cyc(0, OP_BEQ, 0, 1, E_F,  5);
    cyc(0, OP_BEQ, 0, 1, E_D,  5);
    cyc(0, OP_BEQ, 0, 1, E_BN, 5);
    // jal.
    cyc(0, OP_JAL, 0, 1, E_F,   6);
    cyc(0, OP_JAL, 0, 1, E_D,   6);
    cyc(0, OP_JAL, 0, 1, E_J,   6);
    cyc(0, OP_JAL, 0, 1, E_AWB, 6);
    // Unsupported opcode: pulse in DECODE, back to FETCH, no retire.
    cyc(0, OP_BAD, 0, 1, E_F,  7);
    cyc(0, OP_BAD, 0, 1, E_DI, 7);
    // Reset asserted in MEMWRITE: no write, FETCH next, counter cleared.
    cyc(0, OP_SW, 0, 1, E_F,   7);
    cyc(0, OP_SW, 0, 1, E_D,   7);
    cyc(0, OP_SW, 0, 1, E_MA,  7);
    cyc(1, OP_SW, 0, 1, E_RST, 7);
    cyc(0, OP_SW, 0, 1, E_F,   0);
    cyc(0, OP_SW, 0, 1, E_D,   0);
    cyc(0, OP_SW, 0, 1, E_MA,  0);
    cyc(0, OP_SW, 0, 1, E_MW,  0);
`ifdef MEM_READY_EN
    // FETCH waits one cycle, then lw with two not-ready MEMREAD cycles.
    cyc(0, OP_LW, 0, 0, E_FW,  1);
    cyc(0, OP_LW, 0, 1, E_F,   1);
    cyc(0, OP_LW, 0, 1, E_D,   1);
    cyc(0, OP_LW, 0, 1, E_MA,  1);
    cyc(0, OP_LW, 0, 0, E_MR,  1);
    cyc(0, OP_LW, 0, 0, E_MR,  1);
    cyc(0, OP_LW, 0, 1, E_MR,  1);
    cyc(0, OP_LW, 0, 1, E_MWB, 1);
    // lw whose MEMREAD never completes: timeout on the fourth cycle.
    cyc(0, OP_LW, 0, 1, E_F,   2);
    cyc(0, OP_LW, 0, 1, E_D,   2);
    cyc(0, OP_LW, 0, 1, E_MA,  2);
    cyc(0, OP_LW, 0, 0, E_MR,  2);
    cyc(0, OP_LW, 0, 0, E_MR,  2);
    cyc(0, OP_LW, 0, 0, E_MR,  2);
    cyc(0, OP_LW, 0, 0, E_MRE, 2);
    cyc(0, OP_LW, 0, 1, E_F,   2);
    cyc(0, OP_LW, 0, 1, E_D,   2);
`else
    // mem_ready is ignored: jal runs at full rate with it held low.
    cyc(0, OP_JAL, 0, 0, E_F,   1);
    cyc(0, OP_JAL, 0, 0, E_D,   1);
    cyc(0, OP_JAL, 0, 0, E_J,   1);
    cyc(0, OP_JAL, 0, 0, E_AWB, 1);
    cyc(0, OP_JAL, 0, 0, E_F,   2);
`endif
    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0",
               sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
